// File: rtl/fp24_pkg.sv
// fp24_pkg: shared fp24 format constants and rounding-mode encoding
package fp24_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 15;
  localparam int BIAS = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);
  localparam logic [23:0] FP24_QNAN = 24'h7FC000;
  localparam logic [23:0] FP24_PINF = 24'h7F8000;
  localparam logic [23:0] FP24_MAXF = 24'h7F7FFF;
  typedef enum logic [1:0] {RND_NE, RND_Z, RND_PINF, RND_NINF} rnd_e;
endpackage

// File: rtl/fp24_lzc.sv
// fp24_lzc: leading-zero count of a 19-bit field (x -> n, 19 when x is zero)
module fp24_lzc (
  input  logic [18:0] x,
  output logic [4:0]  n
);
  always_comb begin
    n = 5'd19;
    for (int i = 0; i < 19; i++)
      if (x[i]) n = 5'(18 - i);
  end
endmodule

// File: rtl/fp24_addsub.sv
// fp24_addsub: fp24 add/sub (clock, reset, inst_a, inst_b, inst_rnd, inst_op -> registered z_inst)
module fp24_addsub
  import fp24_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] inst_a,
  input  logic [23:0] inst_b,
  input  logic [2:0]  inst_rnd,
  input  logic        inst_op,
  output logic [23:0] z_inst
);
  logic sa, sb;
  logic [EXP_W-1:0] ea, eb, e_big, e_small, d;
  logic [FRAC_W-1:0] fa, fb, frac;
  logic nan_a, nan_b, inf_a, inf_b, nan_out;
  logic [22:0] ka, kb, k_big, k_small;
  logic swap, s_big, s_small, eff_sub;
  logic [15:0] m_big, m_small, mant;
  logic [4:0] dsat, lz;
  logic [35:0] wide;
  logic [18:0] f_small, norm;
  logic [19:0] sum;
  logic g, rs, inc, away, zero_sign;
  logic signed [9:0] e_norm, e_fin;
  logic [16:0] mant_r;
  rnd_e mode;
  logic [23:0] z_next;
  assign sa = inst_a[23];
  assign sb = inst_b[23] ^ inst_op;
  assign ea = inst_a[22:15];
  assign eb = inst_b[22:15];
  assign fa = inst_a[14:0];
  assign fb = inst_b[14:0];
  assign nan_a = ea == EXP_MAX && fa != '0;
  assign nan_b = eb == EXP_MAX && fb != '0;
  assign inf_a = ea == EXP_MAX && fa == '0;
  assign inf_b = eb == EXP_MAX && fb == '0;
  assign nan_out = nan_a | nan_b | (inf_a & inf_b & (sa ^ sb));
  // subnormals become zero magnitude so they order and add as zero
  assign ka = ea == '0 ? '0 : inst_a[22:0];
  assign kb = eb == '0 ? '0 : inst_b[22:0];
  assign swap = kb > ka;
  assign s_big = swap ? sb : sa;
  assign s_small = swap ? sa : sb;
  assign k_big = swap ? kb : ka;
  assign k_small = swap ? ka : kb;
  assign e_big = k_big[22:15];
  assign e_small = k_small[22:15];
  assign m_big = {|e_big, k_big[14:0]};
  assign m_small = {|e_small, k_small[14:0]};
  assign d = e_big - e_small;
  assign dsat = d > 8'd18 ? 5'd18 : d[4:0];
  // low half of the shifted window collects the bits that fall off into sticky
  assign wide = {m_small, 2'b00, 18'b0} >> dsat;
  assign f_small = {wide[35:18], |wide[17:0]};
  assign eff_sub = s_big ^ s_small;
  assign sum = eff_sub ? {1'b0, m_big, 3'b000} - {1'b0, f_small}
                       : {1'b0, m_big, 3'b000} + {1'b0, f_small};
  fp24_lzc u_lzc (.x(sum[18:0]), .n(lz));
  assign norm = sum[18:0] << lz;
  assign mant = sum[19] ? sum[19:4] : norm[18:3];
  assign g = sum[19] ? sum[3] : norm[2];
  assign rs = sum[19] ? |sum[2:0] : |norm[1:0];
  assign e_norm = sum[19] ? {2'b00, e_big} + 10'd1 : {2'b00, e_big} - {5'b0, lz};
  assign mode = inst_rnd[2] ? RND_NE : rnd_e'(inst_rnd[1:0]);
  assign inc = mode == RND_NE   ? g & (rs | mant[0]) :
               mode == RND_PINF ? (g | rs) & ~s_big :
               mode == RND_NINF ? (g | rs) & s_big : 1'b0;
  assign mant_r = {1'b0, mant} + {16'b0, inc};
  assign e_fin = e_norm + {9'b0, mant_r[16]};
  assign frac = mant_r[16] ? mant_r[15:1] : mant_r[14:0];
  assign away = mode == RND_NE | (mode == RND_PINF & ~s_big) | (mode == RND_NINF & s_big);
  // only two negative zeros can sum to a same-sign zero
  assign zero_sign = (sa & sb) | (eff_sub & mode == RND_NINF);
  assign z_next = nan_out              ? FP24_QNAN :
                  inf_a                ? {sa, FP24_PINF[22:0]} :
                  inf_b                ? {sb, FP24_PINF[22:0]} :
                  sum == '0            ? {zero_sign, 23'b0} :
                  e_fin >= 10'sd255    ? {s_big, away ? FP24_PINF[22:0] : FP24_MAXF[22:0]} :
                  e_fin <= 10'sd0      ? {s_big, 23'b0} :
                  {s_big, e_fin[7:0], frac};
  always_ff @(posedge clock)
    z_inst <= reset ? '0 : z_next;
endmodule

// File: tb/tb_fp24_addsub.sv
// tb_fp24_addsub: directed vectors plus random back-to-back stream against an exact integer model
module tb_fp24_addsub;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [23:0] inst_a = '0, inst_b = '0;
  logic [2:0] inst_rnd = '0;
  logic inst_op = 1'b0;
  logic [23:0] z_inst;
  int errors = 0;
  int checks = 0;

  typedef struct {
    string name;
    logic [23:0] a;
    logic [23:0] b;
    logic op;
    logic [2:0] rnd;
    logic [23:0] z;
  } vec_t;
  vec_t vecs[$];

  fp24_addsub dut (.clock(clock), .reset(reset), .inst_a(inst_a), .inst_b(inst_b),
                   .inst_rnd(inst_rnd), .inst_op(inst_op), .z_inst(z_inst));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [23:0] a, input logic [23:0] b, input logic op, input logic [2:0] rnd);
    inst_a = a;
    inst_b = b;
    inst_op = op;
    inst_rnd = rnd;
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(string n, logic [23:0] a, logic [23:0] b, logic op,
                              logic [2:0] rnd, logic [23:0] z);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.op = op; v.rnd = rnd; v.z = z;
    return v;
  endfunction

  // exact-integer reference for normal operands
  function automatic logic [23:0] ref_add(logic [23:0] a, logic [23:0] b, logic op, logic [2:0] rnd);
    logic sa, sb, sgn, inc;
    int ea, eb, emin, p, sh, e;
    logic [127:0] va, vb, mag, q128, rem, half;
    logic [16:0] q;
    logic [1:0] mode;
    mode = rnd[2] ? 2'd0 : rnd[1:0];
    sa = a[23];
    sb = b[23] ^ op;
    ea = int'(a[22:15]);
    eb = int'(b[22:15]);
    emin = ea < eb ? ea : eb;
    va = 128'({1'b1, a[14:0]}) << (ea - emin);
    vb = 128'({1'b1, b[14:0]}) << (eb - emin);
    if (sa == sb) begin mag = va + vb; sgn = sa; end
    else if (va >= vb) begin mag = va - vb; sgn = sa; end
    else begin mag = vb - va; sgn = sb; end
    if (mag == 0) return mode == 2'd3 ? 24'h800000 : 24'h000000;
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    if (p > 15) begin
      sh = p - 15;
      q128 = mag >> sh;
      rem = mag - (q128 << sh);
      half = 128'd1 << (sh - 1);
    end else begin
      q128 = mag << (15 - p);
      rem = 0;
      half = 1;
    end
    q = q128[16:0];
    e = emin + p - 15;
    case (mode)
      2'd0: inc = (rem > half) || (rem == half && q[0]);
      2'd2: inc = rem != 0 && !sgn;
      2'd3: inc = rem != 0 && sgn;
      default: inc = 1'b0;
    endcase
    q = q + 17'(inc);
    if (q[16]) begin q = q >> 1; e = e + 1; end
    return {sgn, 8'(e), q[14:0]};
  endfunction

  initial begin
    vecs.push_back(mk("add_1_2",      24'h3F8000, 24'h400000, 1'b0, 3'b000, 24'h404000));
    vecs.push_back(mk("sub_3_1",      24'h404000, 24'h3F8000, 1'b1, 3'b000, 24'h400000));
    vecs.push_back(mk("sub_equal",    24'h3F8000, 24'h3F8000, 1'b1, 3'b000, 24'h000000));
    vecs.push_back(mk("tie_ne",       24'h3F8000, 24'h378000, 1'b0, 3'b000, 24'h3F8000));
    vecs.push_back(mk("tie_pinf",     24'h3F8000, 24'h378000, 1'b0, 3'b010, 24'h3F8001));
    vecs.push_back(mk("tie_z",        24'h3F8000, 24'h378000, 1'b0, 3'b001, 24'h3F8000));
    vecs.push_back(mk("tie_sub_ninf", 24'h3F8000, 24'h378000, 1'b1, 3'b011, 24'h3F7FFF));
    vecs.push_back(mk("tie_rnd1xx",   24'h3F8000, 24'h378000, 1'b0, 3'b110, 24'h3F8000));
    vecs.push_back(mk("tie_odd_ne",   24'h3F8001, 24'h378000, 1'b0, 3'b000, 24'h3F8002));
    vecs.push_back(mk("ovf_ne",       24'h7F7FFF, 24'h7F7FFF, 1'b0, 3'b000, 24'h7F8000));
    vecs.push_back(mk("ovf_z",        24'h7F7FFF, 24'h7F7FFF, 1'b0, 3'b001, 24'h7F7FFF));
    vecs.push_back(mk("ovf_neg_ninf", 24'hFF7FFF, 24'hFF7FFF, 1'b0, 3'b011, 24'hFF8000));
    vecs.push_back(mk("ovf_neg_pinf", 24'hFF7FFF, 24'hFF7FFF, 1'b0, 3'b010, 24'hFF7FFF));
    vecs.push_back(mk("inf_m_inf",    24'h7F8000, 24'h7F8000, 1'b1, 3'b000, 24'h7FC000));
    vecs.push_back(mk("inf_p_fin",    24'h7F8000, 24'h3F8000, 1'b0, 3'b000, 24'h7F8000));
    vecs.push_back(mk("fin_m_inf",    24'h3F8000, 24'h7F8000, 1'b1, 3'b000, 24'hFF8000));
    vecs.push_back(mk("nan_in",       24'h7FC001, 24'h3F8000, 1'b0, 3'b000, 24'h7FC000));
    vecs.push_back(mk("negz_negz",    24'h800000, 24'h800000, 1'b0, 3'b000, 24'h800000));
    vecs.push_back(mk("cancel_ninf",  24'h3F8000, 24'h3F8000, 1'b1, 3'b011, 24'h800000));
    vecs.push_back(mk("subnorm_flush",24'h000001, 24'h3F8000, 1'b0, 3'b000, 24'h3F8000));
    vecs.push_back(mk("underflow",    24'h008001, 24'h008000, 1'b1, 3'b000, 24'h000000));
    vecs.push_back(mk("far_sticky",   24'h3F8000, 24'h008000, 1'b1, 3'b011, 24'h3F7FFF));

    drive(24'h3F8000, 24'h3F8000, 1'b0, 3'b000);
    chk("reset_hold", z_inst, 24'h000000);
    drive(24'h3F8000, 24'h3F8000, 1'b0, 3'b000);
    chk("reset_hold2", z_inst, 24'h000000);
    reset = 1'b0;
    drive(24'h3F8000, 24'h3F8000, 1'b0, 3'b000);
    chk("first_after_reset", z_inst, 24'h400000);

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].rnd);
      chk(vecs[i].name, z_inst, vecs[i].z);
    end

    reset = 1'b1;
    drive(24'h3F8000, 24'h400000, 1'b0, 3'b000);
    chk("midstream_reset", z_inst, 24'h000000);
    reset = 1'b0;
    drive(24'h3F8000, 24'h400000, 1'b0, 3'b000);
    chk("resume_after_reset", z_inst, 24'h404000);

    for (int i = 0; i < 1000; i++) begin
      int ea, eb;
      logic [23:0] a, b;
      logic op;
      logic [2:0] rnd;
      ea = int'($urandom_range(100, 160));
      eb = (i % 2 == 1) ? ea + int'($urandom_range(0, 4)) - 2 : int'($urandom_range(100, 160));
      a = {1'($urandom), 8'(ea), 15'($urandom)};
      b = {1'($urandom), 8'(eb), 15'($urandom)};
      op = 1'($urandom);
      rnd = 3'($urandom);
      drive(a, b, op, rnd);
      chk("rand", z_inst, ref_add(a, b, op, rnd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
